cic_decimator_mc: RTL and testbench

- Multi-channel, time-interleaved CIC decimator with a runtime-programmable decimation ratio and output scaling.
- Successor to the single-channel fixed-R CIC; serves up to NUM_CH channels through one shared datapath.
- Sits between a TDM sample source and downstream compensation FIR.
- Ready/valid on both sides; back-pressure propagates upstream.

---
 rtl/cic_decimator_mc.sv | 145 ++++++++++++++
 tb/tb_cic_decimator_mc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator_mc.sv
// Time-interleaved multi-channel CIC decimator. One integrator/comb datapath is
// shared by all channels; per-channel state lives in packed arrays indexed by channel.
module cic_decimator_mc #(
  parameter int NUM_CH    = 4,
  parameter int STAGES    = 3,
  parameter int R_MAX     = 16,
  parameter int M         = 1,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 24,
  localparam int FULL_W = IN_WIDTH + STAGES * $clog2(R_MAX * M),
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int RW     = $clog2(R_MAX + 1),
  localparam int SW     = $clog2(FULL_W)
) (
  input  logic                        in_clock,
  input  logic                        in_reset_n,
  input  logic                        cfg_load,
  input  logic [RW-1:0]               cfg_rate,
  input  logic [SW-1:0]               cfg_shift,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic [CHW-1:0]              in_chan,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [CHW-1:0]              out_chan,
  output logic                        seq_err
);

  typedef struct packed {
    logic [CHW-1:0]    chan;
    logic [FULL_W-1:0] val;
  } p1_t;

  localparam logic [RW-1:0]  RMAX_V  = RW'(R_MAX);
  localparam logic [SW-1:0]  SHMAX_V = SW'(FULL_W - 1);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);
  localparam logic signed [FULL_W:0] SAT_MAX =
    $signed(((FULL_W+1)'(1) << (OUT_WIDTH - 1)) - (FULL_W+1)'(1));
  localparam logic signed [FULL_W:0] SAT_MIN = ~SAT_MAX;

  if (M != 1 && M != 2) begin : g_chk_m
    $error("cic_decimator_mc: M must be 1 or 2");
  end
  if (OUT_WIDTH < 2 || OUT_WIDTH > FULL_W) begin : g_chk_ow
    $error("cic_decimator_mc: OUT_WIDTH must be in 2..FULL_W");
  end

  logic [NUM_CH-1:0][STAGES-1:0][FULL_W-1:0]        integ;
  logic [NUM_CH-1:0][STAGES-1:0][M-1:0][FULL_W-1:0] dly;
  logic [STAGES-1:0][FULL_W-1:0]                    int_nx;
  logic [STAGES-1:0][M-1:0][FULL_W-1:0]             dly_nx;
  logic [FULL_W-1:0]    int_acc, comb_v, comb_d;
  logic [RW-1:0]        rate, frame;
  logic [SW-1:0]        shift;
  logic [CHW-1:0]       exp_ch;
  p1_t                  p1;
  logic                 p1_fire, adv, chan_ok, last_ch, dec_smp;
  logic [FULL_W:0]      rnd_add, rnd;
  logic signed [FULL_W:0] shd;
  logic [OUT_WIDTH-1:0] sat;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign chan_ok  = (in_chan == exp_ch);
  assign last_ch  = (exp_ch == LAST_CH);
  assign dec_smp  = (frame == rate - RW'(1));

  // Integrator ripple: each stage adds the freshly updated value of the stage before it.
  always_comb begin
    int_acc = FULL_W'(in_data);
    int_nx  = integ[in_chan];
    for (int s = 0; s < STAGES; s++) begin
      int_nx[s] = integ[in_chan][s] + int_acc;
      int_acc   = int_nx[s];
    end
  end

  always_comb begin
    comb_v = p1.val;
    comb_d = '0;
    dly_nx = dly[p1.chan];
    for (int s = 0; s < STAGES; s++) begin
      comb_d = comb_v - dly[p1.chan][s][M-1];
      for (int j = M - 1; j > 0; j--) dly_nx[s][j] = dly[p1.chan][s][j-1];
      dly_nx[s][0] = comb_v;
      comb_v = comb_d;
    end
  end

  // One extra bit keeps the rounding add from overflowing before the shift.
  always_comb begin
    rnd_add = ((FULL_W+1)'(1) << shift) >> 1;
    rnd     = {comb_v[FULL_W-1], comb_v} + rnd_add;
    shd     = $signed(rnd) >>> shift;
    if (shd > SAT_MAX)      sat = SAT_MAX[OUT_WIDTH-1:0];
    else if (shd < SAT_MIN) sat = SAT_MIN[OUT_WIDTH-1:0];
    else                    sat = shd[OUT_WIDTH-1:0];
  end

  always_ff @(posedge in_clock) begin
    if (!in_reset_n || cfg_load) begin
      integ     <= '0;
      dly       <= '0;
      exp_ch    <= '0;
      frame     <= '0;
      p1        <= '0;
      p1_fire   <= 1'b0;
      out_valid <= 1'b0;
      seq_err   <= 1'b0;
      if (!in_reset_n) begin
        rate     <= RMAX_V;
        shift    <= '0;
        out_data <= '0;
        out_chan <= '0;
      end else begin
        rate  <= (cfg_rate == '0) ? RW'(1) : (cfg_rate > RMAX_V) ? RMAX_V : cfg_rate;
        shift <= (cfg_shift > SHMAX_V) ? SHMAX_V : cfg_shift;
      end
    end else if (adv) begin
      p1_fire <= 1'b0;
      if (in_valid) begin
        if (!chan_ok) begin
          seq_err <= 1'b1;
        end else begin
          integ[in_chan] <= int_nx;
          exp_ch         <= last_ch ? '0 : exp_ch + CHW'(1);
          if (last_ch) frame <= dec_smp ? '0 : frame + RW'(1);
          if (dec_smp) begin
            p1_fire <= 1'b1;
            p1      <= '{chan: in_chan, val: int_nx[STAGES-1]};
          end
        end
      end
      out_valid <= p1_fire;
      if (p1_fire) begin
        dly[p1.chan] <= dly_nx;
        out_data     <= sat;
        out_chan     <= p1.chan;
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Randomized and directed bench for cic_decimator_mc against a per-channel model
// that uses running sums and an S-th order finite difference of the decimated stream.
module tb_cic_decimator_mc;
  localparam int NC  = 2;
  localparam int ST  = 3;
  localparam int RMX = 16;
  localparam int MM  = 1;
  localparam int IW  = 16;
  localparam int OW  = 12;
  localparam int FW  = IW + ST * $clog2(RMX * MM);
  localparam int CHW = (NC > 1) ? $clog2(NC) : 1;
  localparam int RW  = $clog2(RMX + 1);
  localparam int SW  = $clog2(FW);

  logic in_clock = 0, in_reset_n = 0, cfg_load = 0, in_valid = 0, out_ready = 0;
  logic [RW-1:0] cfg_rate = '0;
  logic [SW-1:0] cfg_shift = '0;
  logic signed [IW-1:0] in_data = '0;
  logic [CHW-1:0] in_chan = '0;
  logic in_ready, out_valid, seq_err;
  logic signed [OW-1:0] out_data;
  logic [CHW-1:0] out_chan;

  cic_decimator_mc #(.NUM_CH(NC), .STAGES(ST), .R_MAX(RMX), .M(MM),
                     .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .in_clock(in_clock), .in_reset_n(in_reset_n), .cfg_load(cfg_load),
    .cfg_rate(cfg_rate), .cfg_shift(cfg_shift), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_chan(in_chan),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .seq_err(seq_err));

  always #5 in_clock = ~in_clock;

  typedef struct { int ch; longint d; } exp_t;
  exp_t   q[$];
  exp_t   e_cur;
  longint m_int [NC][ST];
  longint hist [NC][$];
  int     m_r, m_sh, m_exp, m_frame;
  bit     m_seq;
  int     cyc = 0, lat_acc = -1;
  bit     lat_armed, cfg_seen, hold_pend;
  longint hold_d;
  int     hold_c;
  longint last_out [NC];
  int     n_chk = 0, n_pass = 0;
  int     d_exp = 0;
  int     dc [NC];
  int     rl [6] = '{1, 16, 7, 31, 0, 3};
  int     sl [6] = '{0, 27, 31, 10, 5, 15};

  task automatic chk(string nm, logic signed [63:0] act, logic signed [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, want, cyc);
  endtask

  function automatic longint wrapw(longint v);
    logic signed [FW-1:0] t;
    t = FW'(v);
    return longint'(t);
  endfunction

  function automatic longint binom(int n, int k);
    longint r = 1;
    for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
    return r;
  endfunction

  function automatic longint scale(longint y, int sh);
    longint v, hi;
    hi = (longint'(1) << (OW - 1)) - 1;
    v = y;
    if (sh > 0) v += longint'(1) << (sh - 1);
    v = v >>> sh;
    if (v > hi) v = hi;
    else if (v < -hi - 1) v = -hi - 1;
    return v;
  endfunction

  task automatic m_clear(int r, int sh);
    m_r = r; m_sh = sh; m_exp = 0; m_frame = 0; m_seq = 0;
    foreach (m_int[c, s]) m_int[c][s] = 0;
    for (int c = 0; c < NC; c++) hist[c].delete();
    q.delete();
    lat_armed = 1; lat_acc = -1; hold_pend = 0;
  endtask

  task automatic m_accept(int ch, longint x);
    longint v, y;
    if (ch != m_exp) begin m_seq = 1; return; end
    v = x;
    for (int s = 0; s < ST; s++) begin
      m_int[ch][s] = wrapw(m_int[ch][s] + v);
      v = m_int[ch][s];
    end
    if (m_frame == m_r - 1) begin
      hist[ch].push_front(v);
      if (hist[ch].size() > ST * MM + 1) void'(hist[ch].pop_back());
      y = 0;
      for (int j = 0; j <= ST; j++)
        if (j * MM < hist[ch].size())
          y += ((j % 2) ? -1 : 1) * binom(ST, j) * hist[ch][j*MM];
      q.push_back('{ch, scale(wrapw(y), m_sh)});
      if (lat_acc < 0) lat_acc = cyc;
    end
    if (ch == NC - 1) m_frame = (m_frame == m_r - 1) ? 0 : m_frame + 1;
    m_exp = (m_exp == NC - 1) ? 0 : m_exp + 1;
  endtask

  // Checks the current cycle's outputs, then advances the model by what the next edge will do.
  always @(negedge in_clock) begin
    cyc++;
    if (!in_reset_n) begin
      m_clear(RMX, 0);
      cfg_seen = 0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      chk("seq_err", seq_err, m_seq);
      if (cfg_seen) chk("cfg_clears_valid", out_valid, 0);
      cfg_seen = 0;
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
        chk("hold_chan", out_chan, hold_c);
      end
      if (out_valid && lat_armed) begin
        chk("first_latency", cyc - lat_acc, 2);
        lat_armed = 0;
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_output: got chan %0d data %0d, expected none", out_chan, out_data);
        end else begin
          n_chk--;
          e_cur = q.pop_front();
          chk("out_chan", out_chan, e_cur.ch);
          chk("out_data", out_data, e_cur.d);
        end
        last_out[out_chan] = out_data;
      end
      hold_pend = out_valid && !out_ready;
      hold_d = out_data;
      hold_c = out_chan;
      if (cfg_load) begin
        m_clear(cfg_rate == 0 ? 1 : (int'(cfg_rate) > RMX ? RMX : int'(cfg_rate)),
                int'(cfg_shift) > FW - 1 ? FW - 1 : int'(cfg_shift));
        cfg_seen = 1;
      end else if (in_valid && in_ready) begin
        m_accept(int'(in_chan), longint'(in_data));
      end
    end
  end

  task automatic run(int n, int vpct, int rpct, bit rnd_data, int errpct);
    int ch;
    for (int i = 0; i < n; i++) begin
      ch = ($urandom_range(99) < errpct) ? (d_exp + 1) % NC : d_exp;
      in_valid  = ($urandom_range(99) < vpct);
      in_chan   = CHW'(ch);
      in_data   = rnd_data ? IW'($urandom) : IW'(dc[ch]);
      out_ready = ($urandom_range(99) < rpct);
      @(negedge in_clock);
      if (in_valid && in_ready && ch == d_exp) d_exp = (d_exp + 1) % NC;
      @(posedge in_clock); #1;
    end
  endtask

  task automatic cfg(int r, int s);
    cfg_load = 1; cfg_rate = RW'(r); cfg_shift = SW'(s);
    in_valid = 1; in_chan = '0; in_data = IW'(1234);
    @(posedge in_clock); #1;
    cfg_load = 0; in_valid = 0; d_exp = 0;
  endtask

  task automatic wait_valid(string nm, bit rnd_data);
    int k;
    k = 0;
    while (!out_valid && k < 200) begin run(1, 100, 100, rnd_data, 0); k++; end
    chk(nm, out_valid, 1);
  endtask

  initial begin
    dc[0] = 1; dc[1] = -1;
    repeat (3) @(posedge in_clock);
    #1 in_reset_n = 1;
    @(negedge in_clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge in_clock); #1;

    run(80, 100, 100, 0, 0);                       // default ratio R_MAX

    cfg(4, 0); run(60, 100, 100, 0, 0);
    chk("step_ch0", last_out[0], 64);
    chk("step_ch1", last_out[1], -64);

    dc[0] = 3; dc[1] = 3;
    cfg(4, 7); run(60, 100, 100, 0, 0);
    chk("round_sh7", last_out[0], 2);
    cfg(4, 8); run(60, 100, 100, 0, 0);
    chk("round_sh8", last_out[1], 1);

    dc[0] = 32767; dc[1] = -32768;
    cfg(4, 0); run(60, 100, 100, 0, 0);
    chk("sat_pos", last_out[0], 2047);
    chk("sat_neg", last_out[1], -2048);

    cfg(4, 12);
    wait_valid("stall_wait", 1);
    run(10, 100, 0, 1, 0);
    chk("stall_in_ready", in_ready, 0);
    run(60, 100, 100, 1, 0);

    dc[0] = 5; dc[1] = -7;
    cfg(4, 2);
    run(1, 100, 100, 0, 100);
    chk("seq_err_set", seq_err, 1);
    run(60, 100, 100, 0, 0);
    chk("seq_err_sticky", seq_err, 1);
    chk("seq_ch0", last_out[0], 80);
    chk("seq_ch1", last_out[1], -112);
    cfg(4, 2);
    chk("seq_err_cleared", seq_err, 0);

    dc[0] = 1; dc[1] = -1;
    cfg(4, 0);
    wait_valid("midframe_wait", 0);
    run(3, 100, 0, 0, 0);
    cfg(0, 0);
    chk("cfg_valid_drop", out_valid, 0);
    run(20, 100, 100, 0, 0);
    chk("r1_ch0", last_out[0], 1);
    chk("r1_ch1", last_out[1], -1);
    cfg(31, 4); run(120, 100, 100, 0, 0);
    chk("rclamp_ch0", last_out[0], 256);
    chk("rclamp_ch1", last_out[1], -256);

    for (int k = 0; k < 6; k++) begin
      cfg(rl[k], sl[k]);
      run(300, 70, 70, 1, (k == 2) ? 5 : 0);
    end

    in_valid = 0; out_ready = 1;
    repeat (10) @(posedge in_clock);
    #1;
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
